// File: rtl/warp_stall_tracker.sv
// warp_stall_tracker
//   Per-warp status tracker feeding warp_scheduler. Each warp moves through
//   INACTIVE -> READY -> {LAT_WAIT, MEM_WAIT} -> READY ... -> INACTIVE (exit).
//   Outputs are decoded from registered state only.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   launch_valid/id       launch a warp (must be INACTIVE)
//   issue_valid/id        instruction issue (warp must be READY)
//   issue_lat/mem/exit    issue attributes; exit > mem > lat priority
//   mem_done_valid/id     memory completion (warp must be MEM_WAIT)
//   warp_ready            per-warp READY bit
//   warp_stalled          per-warp LAT_WAIT or MEM_WAIT bit
//   active_count          number of non-INACTIVE warps
//   err                   sticky protocol error

// One warp's state machine and latency down-counter.
module warp_slot #(
    parameter int LAT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             launch_hit,
    input  logic             issue_hit,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic             issue_mem,
    input  logic             issue_exit,
    input  logic             mem_hit,
    output logic             ready,
    output logic             stalled,
    output logic             active,
    output logic             bad
);
    typedef enum logic [1:0] {S_INACTIVE, S_READY, S_LAT_WAIT, S_MEM_WAIT} state_t;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;

    // Legality is judged on state_q only, so an issue landing on the same
    // edge as a latency expiry or mem_done is flagged and dropped while the
    // wakeup still happens.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bad     = 1'b0;
        case (state_q)
            S_INACTIVE: begin
                bad = issue_hit | mem_hit;
                if (launch_hit) state_d = S_READY;
            end
            S_READY: begin
                bad = launch_hit | mem_hit;
                if (issue_hit) begin
                    if (issue_exit)
                        state_d = S_INACTIVE;
                    else if (issue_mem)
                        state_d = S_MEM_WAIT;
                    else if (issue_lat != '0) begin
                        state_d = S_LAT_WAIT;
                        cnt_d   = issue_lat;
                    end
                end
            end
            S_LAT_WAIT: begin
                bad   = launch_hit | issue_hit | mem_hit;
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) state_d = S_READY;
            end
            S_MEM_WAIT: begin
                bad = launch_hit | issue_hit;
                if (mem_hit) state_d = S_READY;
            end
            default: state_d = S_INACTIVE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_INACTIVE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready   = (state_q == S_READY);
    assign stalled = (state_q == S_LAT_WAIT) || (state_q == S_MEM_WAIT);
    assign active  = (state_q != S_INACTIVE);
endmodule

module warp_stall_tracker #(
    parameter int NUM_WARPS = 32,
    parameter int WID_W     = 5,
    parameter int LAT_W     = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 launch_valid,
    input  logic [WID_W-1:0]     launch_id,
    input  logic                 issue_valid,
    input  logic [WID_W-1:0]     issue_id,
    input  logic [LAT_W-1:0]     issue_lat,
    input  logic                 issue_mem,
    input  logic                 issue_exit,
    input  logic                 mem_done_valid,
    input  logic [WID_W-1:0]     mem_done_id,
    output logic [NUM_WARPS-1:0] warp_ready,
    output logic [NUM_WARPS-1:0] warp_stalled,
    output logic [WID_W:0]       active_count,
    output logic                 err
);
    logic [NUM_WARPS-1:0] active, bad;
    logic                 id_oob;
    logic                 err_q;

    // Out-of-range IDs decode to no slot, so they only raise err.
    assign id_oob = (launch_valid   && ({1'b0, launch_id}   >= (WID_W+1)'(NUM_WARPS))) ||
                    (issue_valid    && ({1'b0, issue_id}    >= (WID_W+1)'(NUM_WARPS))) ||
                    (mem_done_valid && ({1'b0, mem_done_id} >= (WID_W+1)'(NUM_WARPS)));

    for (genvar i = 0; i < NUM_WARPS; i++) begin : g_slot
        warp_slot #(.LAT_W(LAT_W)) u_slot (
            .clk        (clk),
            .reset      (reset),
            .launch_hit (launch_valid   && (launch_id   == WID_W'(i))),
            .issue_hit  (issue_valid    && (issue_id    == WID_W'(i))),
            .issue_lat  (issue_lat),
            .issue_mem  (issue_mem),
            .issue_exit (issue_exit),
            .mem_hit    (mem_done_valid && (mem_done_id == WID_W'(i))),
            .ready      (warp_ready[i]),
            .stalled    (warp_stalled[i]),
            .active     (active[i]),
            .bad        (bad[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_q | (|bad) | id_oob;
    end
    assign err = err_q;

    always_comb begin
        active_count = '0;
        for (int i = 0; i < NUM_WARPS; i++)
            active_count = active_count + (WID_W+1)'(active[i]);
    end
endmodule

// File: tb/tb_warp_stall_tracker.sv
module tb_warp_stall_tracker;
    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        launch_valid = 1'b0;
    logic [4:0]  launch_id = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_id = '0;
    logic [5:0]  issue_lat = '0;
    logic        issue_mem = 1'b0;
    logic        issue_exit = 1'b0;
    logic        mem_done_valid = 1'b0;
    logic [4:0]  mem_done_id = '0;
    logic [31:0] warp_ready, warp_stalled;
    logic [5:0]  active_count;
    logic        err;

    int checks = 0;
    int errors = 0;

    warp_stall_tracker dut (
        .clk(clk), .reset(reset),
        .launch_valid(launch_valid), .launch_id(launch_id),
        .issue_valid(issue_valid), .issue_id(issue_id), .issue_lat(issue_lat),
        .issue_mem(issue_mem), .issue_exit(issue_exit),
        .mem_done_valid(mem_done_valid), .mem_done_id(mem_done_id),
        .warp_ready(warp_ready), .warp_stalled(warp_stalled),
        .active_count(active_count), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: what each warp is waiting on, in plain terms.
    bit m_alive[N];
    bit m_memw[N];
    int m_left[N];
    bit m_err;

    function automatic bit m_ready(int i);
        return m_alive[i] && !m_memw[i] && m_left[i] == 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_alive[i] = 0; m_memw[i] = 0; m_left[i] = 0; end
        m_err = 0;
    endtask

    task automatic model_step(input bit lv, input int lid, input bit iv, input int iid,
                              input int lat, input bit im, input bit ie,
                              input bit mv, input int mid);
        bit ok_l, ok_i, ok_m;
        ok_l = lv && lid < N && !m_alive[lid];
        ok_i = iv && iid < N && m_ready(iid);
        ok_m = mv && mid < N && m_memw[mid];
        if ((lv && !ok_l) || (iv && !ok_i) || (mv && !ok_m)) m_err = 1;
        for (int i = 0; i < N; i++) if (m_left[i] > 0) m_left[i]--;
        if (ok_m) m_memw[mid] = 0;
        if (ok_l) m_alive[lid] = 1;
        if (ok_i) begin
            if (ie)      m_alive[iid] = 0;
            else if (im) m_memw[iid] = 1;
            else         m_left[iid] = lat;
        end
    endtask

    function automatic logic [31:0] m_rdy_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_ready(i);
        return v;
    endfunction

    function automatic logic [31:0] m_stl_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_memw[i] || m_left[i] > 0;
        return v;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_alive[i]);
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] er, input logic [31:0] es,
                           input int ec, input bit ee);
        chk({tag, ".ready"},   warp_ready,         er);
        chk({tag, ".stalled"}, warp_stalled,       es);
        chk({tag, ".count"},   32'(active_count),  32'(ec));
        chk({tag, ".err"},     32'(err),           32'(ee));
    endtask

    // Drive one cycle of inputs (called #1 after a posedge), advance the
    // model, clock, and leave time at #1 after the next posedge.
    task automatic apply(input bit lv, input int lid, input bit iv, input int iid,
                         input int lat, input bit im, input bit ie,
                         input bit mv, input int mid);
        launch_valid = lv; launch_id = 5'(lid);
        issue_valid = iv; issue_id = 5'(iid); issue_lat = 6'(lat);
        issue_mem = im; issue_exit = ie;
        mem_done_valid = mv; mem_done_id = 5'(mid);
        model_step(lv, lid, iv, iid, lat, im, ie, mv, mid);
        @(posedge clk); #1;
        launch_valid = 0; issue_valid = 0; mem_done_valid = 0;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 0;
        launch_valid = 0; issue_valid = 0; mem_done_valid = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        model_reset();
    endtask

    typedef struct {
        bit lv; int lid; bit iv; int iid; int lat; bit im; bit ie; bit mv; int mid;
        logic [31:0] er; logic [31:0] es; int ec; bit ee;
    } vec_t;

    function automatic vec_t mk(bit lv, int lid, bit iv, int iid, int lat, bit im, bit ie,
                                bit mv, int mid, logic [31:0] er, logic [31:0] es,
                                int ec, bit ee);
        vec_t v;
        v.lv = lv; v.lid = lid; v.iv = iv; v.iid = iid; v.lat = lat; v.im = im; v.ie = ie;
        v.mv = mv; v.mid = mid; v.er = er; v.es = es; v.ec = ec; v.ee = ee;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // Basic flow: launch, latency stall, mem stall, triple event, late issue.
        tbl.push_back(mk(1,0, 0,0,0,0,0, 0,0, 32'h1, 32'h0, 1, 0)); // launch 0
        tbl.push_back(mk(1,1, 0,0,0,0,0, 0,0, 32'h3, 32'h0, 2, 0)); // launch 1
        tbl.push_back(mk(0,0, 1,0,3,0,0, 0,0, 32'h2, 32'h1, 2, 0)); // issue 0 lat 3
        tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0, 32'h2, 32'h1, 2, 0));
        tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0, 32'h2, 32'h1, 2, 0));
        tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0, 32'h3, 32'h0, 2, 0)); // ready after k+3
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,0, 32'h3, 32'h0, 2, 0)); // lat 0: no stall
        tbl.push_back(mk(0,0, 1,1,9,1,0, 0,0, 32'h1, 32'h2, 2, 0)); // warp 1 mem
        tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0, 32'h1, 32'h2, 2, 0));
        tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0, 32'h1, 32'h2, 2, 0));
        tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0, 32'h1, 32'h2, 2, 0));
        tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0, 32'h1, 32'h2, 2, 0));
        tbl.push_back(mk(1,2, 1,0,0,0,0, 1,1, 32'h7, 32'h0, 3, 0)); // three warps at once
        tbl.push_back(mk(0,0, 1,0,1,0,0, 0,0, 32'h6, 32'h1, 3, 0)); // warp 0 lat 1
        tbl.push_back(mk(0,0, 1,0,0,0,0, 0,0, 32'h7, 32'h0, 3, 1)); // issue on expiry
        tbl.push_back(mk(0,0, 0,0,0,0,0, 0,0, 32'h7, 32'h0, 3, 1)); // err sticky
        tbl.push_back(mk(1,2, 1,2,0,0,1, 0,0, 32'h3, 32'h0, 2, 1)); // launch+exit same warp

        do_reset();
        reset = 0; #1;
        chk_all("reset_state", 32'h0, 32'h0, 0, 0);
        do_reset();

        foreach (tbl[t]) begin
            apply(tbl[t].lv, tbl[t].lid, tbl[t].iv, tbl[t].iid, tbl[t].lat,
                  tbl[t].im, tbl[t].ie, tbl[t].mv, tbl[t].mid);
            chk_all($sformatf("vec%0d", t), tbl[t].er, tbl[t].es, tbl[t].ec, tbl[t].ee);
        end

        // Launch all warps, then exit the last one.
        do_reset();
        for (int i = 0; i < N; i++) apply(1, i, 0, 0, 0, 0, 0, 0, 0);
        chk_all("all_launched", 32'hFFFF_FFFF, 32'h0, 32, 0);
        apply(0, 0, 1, 31, 0, 0, 1, 0, 0);
        chk_all("exit31", 32'h7FFF_FFFF, 32'h0, 31, 0);
        apply(0, 0, 1, 31, 0, 0, 0, 0, 0);                  // issue to exited warp
        chk_all("issue_inactive", 32'h7FFF_FFFF, 32'h0, 31, 1);

        // Reset mid-flight clears waits; stale mem_done then flags err.
        do_reset();
        for (int i = 0; i < 3; i++) apply(1, i, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 1, 0, 0, 0);
        apply(0, 0, 1, 1, 0, 1, 0, 0, 0);
        apply(0, 0, 1, 2, 20, 0, 0, 0, 0);
        chk_all("pre_reset", 32'h0, 32'h7, 3, 0);
        #2 reset = 0;
        #1 chk_all("async_reset", 32'h0, 32'h0, 0, 0);
        #1 reset = 1;
        model_reset();
        @(posedge clk); #1;
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk_all("stale_mem_done", 32'h0, 32'h0, 0, 1);
        idle();
        chk_all("post_reset_idle", 32'h0, 32'h0, 0, 1);

        // Randomized episodes against the model.
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                bit lv, iv, im, ie, mv;
                int lid, iid, lat, mid;
                lv  = ($urandom_range(0, 99) < 40);
                lid = $urandom_range(0, 9);
                iv  = ($urandom_range(0, 99) < 60);
                iid = $urandom_range(0, 9);
                lat = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6);
                im  = ($urandom_range(0, 3) == 0);
                ie  = ($urandom_range(0, 19) == 0);
                mv  = ($urandom_range(0, 99) < 40);
                mid = $urandom_range(0, 9);
                apply(lv, lid, iv, iid, lat, im, ie, mv, mid);
                chk_all($sformatf("rnd%0d_%0d", ep, c), m_rdy_vec(), m_stl_vec(),
                        m_cnt(), m_err);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/warp_stall_tracker.md
# warp_stall_tracker

Per-warp status tracker that generates the `warp_ready` / `warp_stalled` vectors consumed by `warp_scheduler`. It follows each warp through launch, issue, fixed-latency stalls, memory waits and exit, so that the scheduler only sees warps that can legally issue. It sits between the issue stage / memory return path and the scheduler, one instance per SM.

## Interface

- `NUM_WARPS`, 32, number of tracked warps (2..32)
- `WID_W`, 5, warp ID width; must satisfy 2^WID_W >= NUM_WARPS
- `LAT_W`, 6, fixed-latency counter width (max latency 2^LAT_W-1)

Ports:

- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; low clears all state immediately
- `launch_valid`  in  1  launch a warp
- `launch_id`  in  WID_W  warp being launched
- `issue_valid`  in  1  warp issued an instruction this cycle
- `issue_id`  in  WID_W  issuing warp
- `issue_lat`  in  LAT_W  result latency of a non-memory instruction; 0 = no stall
- `issue_mem`  in  1  instruction is a memory op; `issue_lat` ignored
- `issue_exit`  in  1  instruction is EXIT; overrides `issue_mem` and `issue_lat`
- `mem_done_valid`  in  1  memory completion returned
- `mem_done_id`  in  WID_W  warp whose memory op completed
- `warp_ready`  out  NUM_WARPS  bit i = warp i in READY
- `warp_stalled`  out  NUM_WARPS  bit i = warp i in LAT_WAIT or MEM_WAIT
- `active_count`  out  WID_W+1  number of warps not INACTIVE
- `err`  out  1  sticky protocol-error flag

## Operation

- Per-warp state: INACTIVE, READY, LAT_WAIT, MEM_WAIT; per-warp LAT_W-bit down-counter.
- INACTIVE -> READY: `launch_valid` with `launch_id`=i.
- READY -> INACTIVE: issue to i with `issue_exit`=1.
- READY -> MEM_WAIT: issue to i with `issue_mem`=1, `issue_exit`=0.
- READY -> LAT_WAIT: issue to i, non-mem, `issue_lat`=L>0; counter loaded with L.
- READY -> READY: issue to i, non-mem, `issue_lat`=0.
- LAT_WAIT: counter decrements each cycle; when counter==1 it goes to READY (counter -> 0).
- MEM_WAIT -> READY: `mem_done_valid` with `mem_done_id`=i.
- Events on different warps in the same cycle are all applied independently (launch, issue and mem_done may target three different warps).
- Illegal events are ignored (no state change) and set `err`: launch to a non-INACTIVE warp; issue to a non-READY warp; mem_done to a non-MEM_WAIT warp; any ID >= NUM_WARPS.
- Legality is judged on the state at the sampling edge. Consequently, an issue to a warp whose LAT_WAIT expires or whose mem_done arrives in the same cycle is illegal: the issue is dropped and `err` is set, while the expiry or mem_done is still applied.
- Launch and issue to the same warp in one cycle: at most one can be legal. The legal one is applied; the other sets `err`.
- `err` stays high until reset.
- `active_count` is the popcount of non-INACTIVE warps.

## Timing

- Reset (async, `reset`=0):
  - all warps INACTIVE, counters 0
  - `warp_ready`=0, `warp_stalled`=0, `active_count`=0, `err`=0
- Outputs decode state registers only; there is no combinational path from any input to any output.
- All transitions are visible in the cycle after the sampling edge.
- Issue at edge k with latency L>0: `warp_stalled[i]`=1 for exactly L cycles (after edges k..k+L-1), and `warp_ready[i]`=1 again after edge k+L.
- Memory issue at edge k, mem_done sampled at edge m>k: stalled after edges k..m-1, ready after edge m.
- Launch sampled at edge k: `warp_ready[i]`=1 and `active_count` increments after edge k.
- Exit sampled at edge k: both bits clear and `active_count` decrements after edge k.
- Reset mid-operation discards all pending latencies and memory waits. Upstream must drain the memory return path; stale mem_done after reset sets `err`.

## Test plan

- Reset, then launch warps 0 and 1 on consecutive cycles -> `warp_ready`=0x1 then 0x3, `active_count` 1 then 2, `err`=0.
- Warp 0 READY, issue `issue_lat`=3 at edge k -> `warp_stalled[0]`=1 for 3 cycles, `warp_ready[0]` back after edge k+3. Then issue `issue_lat`=0 -> `warp_ready[0]` never drops.
- Warp 1 issue `issue_mem`=1, mem_done for warp 1 five cycles later -> stalled exactly 5 cycles. In the same cycle as that mem_done, launch warp 2 and issue warp 0 -> all three events applied, `err`=0.
- Warp 0 in LAT_WAIT with counter 1, issue to warp 0 that cycle -> warp 0 returns to READY, issue dropped, `err`=1 and stays 1.
- Launch all 32 warps, then exit warp 31 -> `active_count`=32 then 31, `warp_ready`=0x7FFFFFFF.
- Two warps in MEM_WAIT and one in LAT_WAIT, then assert `reset` low between edges -> all outputs 0 immediately. A subsequent mem_done for either MEM_WAIT warp -> `err`=1.
